// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 3
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 Zero;
  logic                 MemReady;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 InstrDone;
  logic [3:0]           State;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite,
    output RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    output ImmSrc, ALUControl, InstrDone, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite,
    input  RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    input  ImmSrc, ALUControl, InstrDone, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory wait states.
// ILLEGAL_TRAP_EN: unlisted opcodes lock the FSM in TRAP until reset.
module multicycle_controller #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam bit WIDE = (ALUCTRL_W == 4);

  state_t               state;
  state_t               state_nx;
  logic [ALUCTRL_W-1:0] alu_f;
  logic [ALUCTRL_W-1:0] alu;
  logic                 pc_update;
  logic                 branch;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic                 done;
  logic [1:0]           result_src;
  logic [1:0]           src_a;
  logic [1:0]           src_b;
  logic [1:0]           imm_src;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= FETCH;
    else        state <= state_nx;
  end

  // sub only for R-type; narrow ALU falls back to add
  always_comb begin
    alu_f = ALUCTRL_W'(ALU_ADD);
    unique case (bus.funct3)
      3'b000: if (bus.funct7b5 && bus.op[5])
                alu_f = ALUCTRL_W'(ALU_SUB);
      3'b010: alu_f = ALUCTRL_W'(ALU_SLT);
      3'b110: alu_f = ALUCTRL_W'(ALU_OR);
      3'b111: alu_f = ALUCTRL_W'(ALU_AND);
      3'b100: if (WIDE) alu_f = ALUCTRL_W'(ALU_XOR);
      3'b001: if (WIDE) alu_f = ALUCTRL_W'(ALU_SLL);
      3'b101: if (WIDE)
                alu_f = bus.funct7b5 ? ALUCTRL_W'(ALU_SRA)
                                     : ALUCTRL_W'(ALU_SRL);
      default: alu_f = ALUCTRL_W'(ALU_ADD);
    endcase
  end

  always_comb begin
    state_nx   = state;
    alu        = ALUCTRL_W'(ALU_ADD);
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    imm_src    = 2'b00;
    case (state)
      FETCH: begin
        ir_write   = bus.MemReady;
        pc_update  = bus.MemReady;
        src_b      = 2'b10;
        result_src = 2'b10;
        if (bus.MemReady) state_nx = DECODE;
      end
      DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        imm_src = 2'b10;
        unique case (bus.op)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_R:         state_nx = EXECUTER;
          OP_I:         state_nx = EXECUTEI;
          OP_B:         state_nx = BEQ;
          OP_JAL:       state_nx = JAL;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nx = TRAP;
`else
            state_nx = FETCH;
            done     = 1'b1;
`endif
          end
        endcase
      end
      MEMADR: begin
        src_a    = 2'b10;
        src_b    = 2'b01;
        imm_src  = bus.op[5] ? 2'b01 : 2'b00;
        state_nx = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (bus.MemReady) state_nx = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_nx   = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        done      = bus.MemReady;
        if (bus.MemReady) state_nx = FETCH;
      end
      EXECUTER: begin
        src_a    = 2'b10;
        alu      = alu_f;
        state_nx = ALUWB;
      end
      EXECUTEI: begin
        src_a    = 2'b10;
        src_b    = 2'b01;
        alu      = alu_f;
        state_nx = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_nx  = FETCH;
      end
      BEQ: begin
        src_a    = 2'b10;
        alu      = ALUCTRL_W'(ALU_SUB);
        branch   = 1'b1;
        done     = 1'b1;
        state_nx = FETCH;
      end
      JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
        state_nx  = ALUWB;
      end
      TRAP:    state_nx = TRAP;
      default: state_nx = FETCH;
    endcase
  end

  // enables are gated by reset so nothing leaks while RST_N is low
  assign bus.PCWrite    = RST_N & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = RST_N & ir_write;
  assign bus.MemWrite   = RST_N & mem_write;
  assign bus.RegWrite   = RST_N & reg_write;
  assign bus.InstrDone  = RST_N & done;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu;
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: route-based model, per-cycle compare,
// plus directed literal checks. Runs a 4-bit and a 3-bit ALU instance.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef int iq_t[$];
  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] alu;
    logic       done;
    logic [3:0] st;
  } exp_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [6:0] op = RT;
  logic [2:0] f3 = 0;
  logic       f7 = 0;
  logic       zero = 0;
  logic       mr = 1;
  int         pos = 0;
  int         errors = 0;
  int         checks = 0;
  int         n_irw, n_mw, n_rw, n_pcw, cyc, cnt;
  logic [15:0] seen;
  logic [3:0] alu4_x;
  logic [2:0] alu3_x;

  always #5 clk = ~clk;

  multicycle_controller_if #(.ALUCTRL_W(4)) bus4 ();
  multicycle_controller_if #(.ALUCTRL_W(3)) bus3 ();

  assign bus4.op = op;
  assign bus4.funct3 = f3;
  assign bus4.funct7b5 = f7;
  assign bus4.Zero = zero;
  assign bus4.MemReady = mr;
  assign bus3.op = op;
  assign bus3.funct3 = f3;
  assign bus3.funct7b5 = f7;
  assign bus3.Zero = zero;
  assign bus3.MemReady = mr;

  multicycle_controller #(.ALUCTRL_W(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .bus(bus4));
  multicycle_controller #(.ALUCTRL_W(3)) dut3 (
    .CLK(clk), .RST_N(rst_n), .bus(bus3));

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, req, $time);
    end
  endfunction

  // the sequence of states an opcode walks through, ignoring stalls
  function automatic iq_t route(input logic [6:0] o);
    iq_t r;
    case (o)
      LW: r = '{0, 1, 2, 3, 4};
      SW: r = '{0, 1, 2, 5};
      RT: r = '{0, 1, 6, 8};
      IT: r = '{0, 1, 7, 8};
      BR: r = '{0, 1, 9};
      JL: r = '{0, 1, 10, 8};
`ifdef ILLEGAL_TRAP_EN
      default: r = '{0, 1, 11};
`else
      default: r = '{0, 1};
`endif
    endcase
    return r;
  endfunction

  function automatic int cur_st();
    iq_t r;
    r = route(op);
    if (pos >= r.size()) return 15;
    return r[pos];
  endfunction

  function automatic int next_pos(input int p);
    iq_t r;
    int  s;
    r = route(op);
    s = r[p];
    if ((s == 0 || s == 3 || s == 5) && !mr) return p;
    if (s == 11) return p;
    if (p + 1 >= r.size()) return 0;
    return p + 1;
  endfunction

  function automatic logic [3:0] alu_exp(input bit w4);
    case (f3)
      3'b000: return (f7 && op == RT) ? 4'd1 : 4'd0;
      3'b010: return 4'd5;
      3'b110: return 4'd3;
      3'b111: return 4'd2;
      3'b100: return w4 ? 4'd4 : 4'd0;
      3'b001: return w4 ? 4'd6 : 4'd0;
      3'b101: return !w4 ? 4'd0 : (f7 ? 4'd15 : 4'd7);
      default: return 4'd0;
    endcase
  endfunction

  function automatic exp_t exp_out(input int s, input bit w4);
    exp_t e;
    bit   legal;
    legal = op inside {LW, SW, RT, IT, BR, JL};
    e = '0;
    e.st = s[3:0];
    case (s)
      0:  begin e.irw = mr; e.pcw = mr; e.sb = 2; e.rs = 2; end
      1:  begin
        e.sa = 1; e.sb = 1; e.imm = 2;
`ifndef ILLEGAL_TRAP_EN
        e.done = !legal;
`endif
      end
      2:  begin e.sa = 2; e.sb = 1; e.imm = (op == SW) ? 2'd1 : 2'd0; end
      3:  e.adr = 1;
      4:  begin e.rs = 1; e.rw = 1; e.done = 1; end
      5:  begin e.adr = 1; e.mw = 1; e.done = mr; end
      6:  begin e.sa = 2; e.alu = alu_exp(w4); end
      7:  begin e.sa = 2; e.sb = 1; e.alu = alu_exp(w4); end
      8:  begin e.rw = 1; e.done = 1; end
      9:  begin e.sa = 2; e.alu = 1; e.pcw = zero; e.done = 1; end
      10: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      default: ;
    endcase
    if (legal && !rst_n) e.st = 0;
    if (!rst_n) begin
      e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0; e.done = 0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= 0;
    else        pos <= next_pos(pos);
  end

  always @(negedge clk) begin
    exp_t e4, e3;
    e4 = exp_out(cur_st(), 1'b1);
    e3 = exp_out(cur_st(), 1'b0);
    chk("State", bus4.State, e4.st);
    chk("PCWrite", bus4.PCWrite, e4.pcw);
    chk("AdrSrc", bus4.AdrSrc, e4.adr);
    chk("MemWrite", bus4.MemWrite, e4.mw);
    chk("IRWrite", bus4.IRWrite, e4.irw);
    chk("RegWrite", bus4.RegWrite, e4.rw);
    chk("ResultSrc", bus4.ResultSrc, e4.rs);
    chk("ALUSrcA", bus4.ALUSrcA, e4.sa);
    chk("ALUSrcB", bus4.ALUSrcB, e4.sb);
    chk("ImmSrc", bus4.ImmSrc, e4.imm);
    chk("ALUControl4", bus4.ALUControl, e4.alu);
    chk("InstrDone", bus4.InstrDone, e4.done);
    chk("State3", bus3.State, e3.st);
    chk("ALUControl3", bus3.ALUControl, e3.alu[2:0]);
    chk("PCWrite3", bus3.PCWrite, e3.pcw);
  end

  task automatic run(input logic [6:0] o, input logic [2:0] fn3,
                     input logic fb5, input logic z,
                     input int fst, input int mst);
    int fc, mc;
    bit dn;
    exp_t e;
    op = o; f3 = fn3; f7 = fb5; zero = z;
    fc = fst; mc = mst; dn = 0;
    cyc = 0; n_irw = 0; n_mw = 0; n_rw = 0; n_pcw = 0;
    seen = 0; alu4_x = 0; alu3_x = 0;
    for (int i = 0; i < 40 && !dn; i++) begin
      int s;
      s = cur_st();
      mr = 1;
      if (s == 0 && fc > 0) begin mr = 0; fc--; end
      if ((s == 3 || s == 5) && mc > 0) begin mr = 0; mc--; end
      @(negedge clk);
      cyc++;
      n_irw += int'(bus4.IRWrite);
      n_mw  += int'(bus4.MemWrite);
      n_rw  += int'(bus4.RegWrite);
      n_pcw += int'(bus4.PCWrite);
      seen = {seen[11:0], bus4.State};
      if (bus4.State == 6 || bus4.State == 7) begin
        alu4_x = bus4.ALUControl;
        alu3_x = bus3.ALUControl;
      end
      e = exp_out(s, 1'b1);
      dn = e.done;
      @(posedge clk); #1;
    end
    mr = 1;
    chk("instr_finished", dn, 1);
  endtask

  initial begin
    #2;
    chk("reset_State", bus4.State, 0);
    chk("reset_IRWrite", bus4.IRWrite, 0);
    chk("reset_PCWrite", bus4.PCWrite, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    run(RT, 3'b000, 0, 0, 0, 0);
    chk("add_cycles", cyc, 4);
    chk("add_states", seen, 16'h0168);
    chk("add_regwrite", n_rw, 1);
    chk("add_alu", alu4_x, 4'b0000);

    run(LW, 3'b010, 0, 0, 2, 1);
    chk("lw_cycles", cyc, 8);
    chk("lw_irwrite", n_irw, 1);
    chk("lw_regwrite", n_rw, 1);

    run(BR, 3'b000, 0, 1, 0, 0);
    chk("beq_taken_cycles", cyc, 3);
    chk("beq_taken_pcw", n_pcw, 2);
    run(BR, 3'b000, 0, 0, 0, 0);
    chk("beq_not_cycles", cyc, 3);
    chk("beq_not_pcw", n_pcw, 1);

    run(RT, 3'b000, 1, 0, 0, 0);
    chk("sub_alu4", alu4_x, 4'b0001);
    chk("sub_alu3", alu3_x, 3'b001);
    run(IT, 3'b000, 1, 0, 0, 0);
    chk("addi_alu4", alu4_x, 4'b0000);
    chk("addi_alu3", alu3_x, 3'b000);
    run(RT, 3'b101, 1, 0, 0, 0);
    chk("sra_alu4", alu4_x, 4'b1111);
    chk("sra_alu3", alu3_x, 3'b000);
    run(IT, 3'b111, 0, 0, 0, 0);
    chk("andi_alu4", alu4_x, 4'b0010);
    run(RT, 3'b100, 0, 0, 0, 0);
    chk("xor_alu4", alu4_x, 4'b0100);
    chk("xor_alu3", alu3_x, 3'b000);

    run(SW, 3'b010, 0, 0, 0, 3);
    chk("sw_cycles", cyc, 7);
    chk("sw_memwrite", n_mw, 4);

    run(JL, 3'b000, 0, 0, 0, 0);
    chk("jal_cycles", cyc, 4);
    chk("jal_pcw", n_pcw, 2);

    op = SW; f3 = 3'b010; mr = 1;
    for (int i = 0; i < 10 && cur_st() != 5; i++) begin
      @(posedge clk); #1;
    end
    mr = 0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("stall_State", bus4.State, 5);
    chk("stall_MemWrite", bus4.MemWrite, 1);
    rst_n = 0;
    #1;
    chk("rst_MemWrite", bus4.MemWrite, 0);
    chk("rst_State", bus4.State, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1; mr = 1;

    run(RT, 3'b110, 0, 0, 0, 0);
    chk("or_after_rst_cycles", cyc, 4);
    chk("or_alu4", alu4_x, 4'b0011);

`ifdef ILLEGAL_TRAP_EN
    op = BAD; cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus4.State == 11) cnt++;
      @(posedge clk); #1;
    end
    chk("trap_hold", cnt, 12);
    rst_n = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    run(RT, 3'b000, 0, 0, 0, 0);
    chk("trap_recover_cycles", cyc, 4);
`else
    run(BAD, 3'b000, 0, 0, 0, 0);
    chk("illegal_cycles", cyc, 2);
    chk("illegal_states", seen[7:0], 8'h01);
    run(RT, 3'b000, 0, 0, 0, 0);
    chk("after_illegal_cycles", cyc, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
